// File: rtl/systolic_sched.sv
// Sequencer for one matrix multiply on a systolic array. It stages N operand beats,
// replays them as a contiguous burst, captures N result rows and drains them downstream.
module systolic_sched #(
  parameter int N_SIZE  = 3,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 64,
  localparam int IDX_W  = (N_SIZE > 1) ? $clog2(N_SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [N_SIZE*DATA_W-1:0]   op_a_col,
  input  logic [N_SIZE*DATA_W-1:0]   op_b_row,
  output logic                       arr_valid_in,
  output logic [N_SIZE*DATA_W-1:0]   arr_a,
  output logic [N_SIZE*DATA_W-1:0]   arr_b,
  input  logic                       arr_valid_out,
  input  logic [N_SIZE*ACC_W-1:0]    arr_c,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N_SIZE*ACC_W-1:0]    res_row,
  output logic [IDX_W-1:0]           res_idx,
  output logic                       res_last
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_SIZE - 1);
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, FEED, WAIT, CAPTURE, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [TW-1:0]             wcnt, wcnt_nxt;
  logic                      op_fire, cap_fire, done_nxt, error_nxt;
  logic [N_SIZE*DATA_W-1:0]  stage_a [N_SIZE];
  logic [N_SIZE*DATA_W-1:0]  stage_b [N_SIZE];
  logic [N_SIZE*ACC_W-1:0]   res_buf [N_SIZE];
  logic [N_SIZE*DATA_W-1:0]  feed_a, feed_b;
  logic [N_SIZE*ACC_W-1:0]   drain_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // idx is the slot pointer for every phase; wcnt only runs in WAIT
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    op_fire   = 1'b0;
    cap_fire  = 1'b0;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt  = '0;
        wcnt_nxt = '0;
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (op_valid && op_ready) begin
          op_fire = 1'b1;
          if (idx == LAST) begin
            state_nxt = FEED;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      FEED: begin
        if (idx == LAST) begin
          state_nxt = WAIT;
          idx_nxt   = '0;
          wcnt_nxt  = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      WAIT: begin
        if (arr_valid_out) begin
          cap_fire = 1'b1;
          if (idx == LAST) begin
            state_nxt = DRAIN;
            idx_nxt   = '0;
          end else begin
            state_nxt = CAPTURE;
            idx_nxt   = idx + IDX_W'(1);
          end
        end else if (wcnt == T_LAST) begin
          state_nxt = IDLE;
          error_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + TW'(1);
        end
      end
      CAPTURE: begin
        if (arr_valid_out) begin
          cap_fire = 1'b1;
          if (idx == LAST) begin
            state_nxt = DRAIN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          state_nxt = IDLE;
          error_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (idx == LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      error_nxt = 1'b0;
    end
  end

  // Bypass covers the single-slot case where the slot being written is read the same cycle
  always_comb begin
    feed_a    = stage_a[idx_nxt];
    feed_b    = stage_b[idx_nxt];
    drain_row = res_buf[idx_nxt];
    if (op_fire && (idx == idx_nxt)) begin
      feed_a = op_a_col;
      feed_b = op_b_row;
    end
    if (cap_fire && (idx == idx_nxt)) drain_row = arr_c;
  end

  always_ff @(posedge clk) begin
    if (op_fire) begin
      stage_a[idx] <= op_a_col;
      stage_b[idx] <= op_b_row;
    end
    if (cap_fire) res_buf[idx] <= arr_c;
  end

  // Outputs are registered from the next-state view so they line up with the state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      op_ready     <= 1'b0;
      arr_valid_in <= 1'b0;
      arr_a        <= '0;
      arr_b        <= '0;
      res_valid    <= 1'b0;
      res_row      <= '0;
      res_idx      <= '0;
      res_last     <= 1'b0;
    end else begin
      busy         <= (state_nxt != IDLE);
      done         <= done_nxt;
      error        <= error_nxt;
      op_ready     <= (state_nxt == COLLECT);
      arr_valid_in <= (state_nxt == FEED);
      arr_a        <= (state_nxt == FEED) ? feed_a : '0;
      arr_b        <= (state_nxt == FEED) ? feed_b : '0;
      res_valid    <= (state_nxt == DRAIN);
      res_row      <= (state_nxt == DRAIN) ? drain_row : '0;
      res_idx      <= (state_nxt == DRAIN) ? idx_nxt : '0;
      res_last     <= (state_nxt == DRAIN) && (idx_nxt == LAST);
    end
  end

endmodule
